ra_wrbuf_sdr: RTL and testbench
===============================

Name: ra_wrbuf_sdr

Overview:
- Write-staging buffer directly upstream of the 64x72 2R1W SDR array write port, between the BIST mux output and the array.
- Absorbs writes with a valid/ready handshake and holds them while the write port is blocked.
- Drains one write per cycle to the array.
- Forwards pending write data to both read ports, aligned with array read data, so reads never return stale data.

Parameters:
- DEPTH, 4, number of buffer entries (power of 2, ≥2)
- ADR_W, 6, write/read address width
- DAT_W, 72, data width
- RD_LAT, 1, array read latency in cycles; the forward result is delayed to match

Ports:
- clk  in  1  array clock; single clock domain
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_val  in  1  upstream write request valid
- in_rdy  out  1  buffer can accept a write
- in_adr  in  ADR_W  upstream write address
- in_dat  in  DAT_W  upstream write data
- hold  in  1  block draining (array strobe disabled / config write in progress)
- wr_enb  out  1  to array wr_enb_0
- wr_adr  out  ADR_W  to array wr_adr_0
- wr_dat  out  DAT_W  to array wr_dat_0
- rd0_enb  in  1  read port 0 request (same signal sent to array)
- rd0_adr  in  ADR_W  read port 0 address
- rd1_enb  in  1  read port 1 request
- rd1_adr  in  ADR_W  read port 1 address
- fwd0_hit  out  1  port 0 pending-write hit, aligned with array rd_dat_0
- fwd0_dat  out  DAT_W  forwarded data for port 0
- fwd1_hit  out  1  port 1 hit
- fwd1_dat  out  DAT_W  forwarded data for port 1
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular FIFO of {adr, dat}; head/tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Reset (reset=0, async): count=0, pointers=0, all outputs 0, all forward pipeline stages cleared. Entry contents need not be cleared. A reset mid-drain discards all pending writes.
- in_rdy = (count < DEPTH). It is combinational from count only and does not look ahead at a same-cycle pop: full means in_rdy=0 even when a drain occurs that cycle.
- Push: when in_val & in_rdy at a rising edge, write {in_adr, in_dat} at tail and increment tail.
- Pop: wr_enb = (count > 0) & ~hold, combinational.
  - wr_adr/wr_dat = head entry when wr_enb=1, else 0.
  - Head advances at the edge where wr_enb=1. The array performs the write in that same cycle.
- Push and pop in the same cycle: count unchanged.
- Empty buffer with push: the entry is not written through the same cycle; the earliest drain is the next cycle (1-cycle minimum latency, in to array).
- Forward compare, cycle N:
  - For each port with rdX_enb=1, compare rdX_adr against all valid entries, including the head entry draining in cycle N.
  - The incoming push of cycle N is excluded.
  - Multiple matches: the youngest entry (closest to tail) wins.
  - The result {hit, dat} is piped through RD_LAT register stages; fwdX_hit/fwdX_dat appear at N+RD_LAT.
  - When hit=0, fwdX_dat=0. When rdX_enb=0, hit=0.
- Both read ports are independent; both may hit the same entry.
- hold asserted while full: in_rdy=0 and the contents are frozen. Forwarding continues normally.

Optional Feature:
- Macro: RA_WRBUF_COALESCE_EN.
- Defined:
  - A push whose in_adr matches a valid entry that is not popping this cycle overwrites that entry's data in place (the youngest match, if more than one).
  - No new entry is allocated and count is unchanged by the push.
  - in_rdy rule is unchanged.
- Undefined: every push allocates a new entry; duplicate addresses coexist and drain in order.

Decomposition:
- Shared package ra_pkg holds:
  - typedef ra_wrent_t {adr, dat}
  - constants RA_ADR_W=6, RA_DAT_W=72
  - a function returning the youngest-match one-hot over a valid vector
- One sub-module: ra_wrbuf_fwd, a single-port compare/priority-select plus RD_LAT delay line, instantiated twice.

Test Plan:
- Reset, then push adr 0,2,4,6 with data 0x11..,0x22..,0x33..,0x44.. and hold=0 -> wr_enb high for 4 consecutive cycles starting one cycle after the first push; addresses 0,2,4,6 in order; count returns to 0.
- hold=1 and push 5 writes -> in_rdy drops after the 4th, count=4, wr_enb=0. Release hold -> 4 drains in order, in_rdy rises the cycle after the first pop.
- hold=1, push adr 8 data A then adr 8 data B; rd0 adr 8 -> fwd0_hit=1 with data B one cycle later; rd1 adr 9 -> fwd1_hit=0, fwd1_dat=0.
- Read the head address in the same cycle it drains -> fwd hit=1 with head data.
- Assert reset (reset=0) with count=3 mid-drain -> immediately wr_enb=0, count=0, fwd outputs 0; no further writes after release.
- With RA_WRBUF_COALESCE_EN: hold=1, push adr 3 data C then adr 3 data D -> count=1; after release, a single write of adr 3 data D.

Source files
------------

// File: rtl/ra_pkg.sv
// Shared types and helpers for the SDR array write-staging buffer.
// Entry layout and youngest-match priority select used by buffer and forwarding.
package ra_pkg;

  localparam int RA_ADR_W     = 6;
  localparam int RA_DAT_W     = 72;
  localparam int RA_MAX_DEPTH = 16;

  typedef struct packed {
    logic [RA_ADR_W-1:0] adr;
    logic [RA_DAT_W-1:0] dat;
  } ra_wrent_t;

  // Input is age-ordered (bit 0 = oldest); the highest set bit is the youngest match.
  function automatic logic [RA_MAX_DEPTH-1:0] ra_youngest_oh(input logic [RA_MAX_DEPTH-1:0] match_age);
    logic [RA_MAX_DEPTH-1:0] oh;
    oh = {RA_MAX_DEPTH{1'b0}};
    for (int i = 0; i < RA_MAX_DEPTH; i++) begin
      if (match_age[i]) begin
        oh    = {RA_MAX_DEPTH{1'b0}};
        oh[i] = 1'b1;
      end else begin
        oh = oh;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/ra_wrbuf_fwd.sv
// Single read-port forwarding: compare against pending entries, pick the youngest
// match, and delay the result by RD_LAT cycles to line up with array read data.
module ra_wrbuf_fwd
  import ra_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADR_W  = RA_ADR_W,
  parameter int DAT_W  = RA_DAT_W,
  parameter int RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_enb_i,
  input  logic [ADR_W-1:0]             rd_adr_i,
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [DEPTH-1:0][ADR_W-1:0]  adr_i,
  input  logic [DEPTH-1:0][DAT_W-1:0]  dat_i,
  output logic                         hit_o,
  output logic [DAT_W-1:0]             dat_o
);

  logic [DEPTH-1:0] match_s;
  logic [DEPTH-1:0] sel_s;
  logic             hit_s;
  logic [DAT_W-1:0] dat_s;

  logic [RD_LAT-1:0] hit_q;
  logic [DAT_W-1:0]  dat_q [RD_LAT];

  // Compare and youngest-wins select; data is zero whenever there is no hit.
  always_comb begin
    match_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      match_s[k] = rd_enb_i & vld_i[k] & (adr_i[k] == rd_adr_i);
    end
    sel_s = DEPTH'(ra_youngest_oh(RA_MAX_DEPTH'(match_s)));
    dat_s = {DAT_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      dat_s = dat_s | (dat_i[k] & {DAT_W{sel_s[k]}});
    end
    hit_s = |match_s;
  end

  // Latency-matching delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= {DAT_W{1'b0}};
      end
    end else begin
      hit_q[0] <= hit_s;
      dat_q[0] <= dat_s;
      for (int i = 1; i < RD_LAT; i++) begin
        hit_q[i] <= hit_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign hit_o = hit_q[RD_LAT-1];
  assign dat_o = dat_q[RD_LAT-1];

endmodule

// File: rtl/ra_wrbuf_sdr.sv
// Write-staging FIFO in front of the 64x72 2R1W SDR array write port with read forwarding.
// Optional in-place write coalescing is enabled by defining RA_WRBUF_COALESCE_EN.
module ra_wrbuf_sdr
  import ra_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADR_W  = RA_ADR_W,
  parameter int DAT_W  = RA_DAT_W,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [ADR_W-1:0]       in_adr,
  input  logic [DAT_W-1:0]       in_dat,
  input  logic                   hold,
  output logic                   wr_enb,
  output logic [ADR_W-1:0]       wr_adr,
  output logic [DAT_W-1:0]       wr_dat,
  input  logic                   rd0_enb,
  input  logic [ADR_W-1:0]       rd0_adr,
  input  logic                   rd1_enb,
  input  logic [ADR_W-1:0]       rd1_adr,
  output logic                   fwd0_hit,
  output logic [DAT_W-1:0]       fwd0_dat,
  output logic                   fwd1_hit,
  output logic [DAT_W-1:0]       fwd1_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  ra_wrent_t        ent_q [DEPTH];

  logic push_s;
  logic pop_s;
  logic alloc_s;
  logic coal_s;

  logic [PTR_W-1:0]             age_idx_s [DEPTH];
  logic [DEPTH-1:0]             vld_age_s;
  logic [DEPTH-1:0][ADR_W-1:0]  adr_age_s;
  logic [DEPTH-1:0][DAT_W-1:0]  dat_age_s;

  assign in_rdy = (count_q < CNT_W'(DEPTH));
  assign push_s = in_val & in_rdy;
  assign pop_s  = (count_q != {CNT_W{1'b0}}) & ~hold;
  assign wr_enb = pop_s;
  assign count  = count_q;

  // Age-ordered view of occupied entries, oldest (head) first; the draining head is included.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_idx_s[k] = head_q + PTR_W'(k);
      vld_age_s[k] = (CNT_W'(k) < count_q);
      adr_age_s[k] = ent_q[age_idx_s[k]].adr;
      dat_age_s[k] = ent_q[age_idx_s[k]].dat;
    end
  end

`ifdef RA_WRBUF_COALESCE_EN
  logic [DEPTH-1:0] cmatch_s;
  logic [DEPTH-1:0] csel_s;
  logic [PTR_W-1:0] cidx_s;

  // A push may merge into the youngest same-address entry unless that entry is leaving now.
  always_comb begin
    cmatch_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      cmatch_s[k] = push_s & vld_age_s[k] & (adr_age_s[k] == in_adr) & ~((k == 0) & pop_s);
    end
    csel_s = DEPTH'(ra_youngest_oh(RA_MAX_DEPTH'(cmatch_s)));
    cidx_s = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (csel_s[k]) begin
        cidx_s = age_idx_s[k];
      end else begin
        cidx_s = cidx_s;
      end
    end
    coal_s = |cmatch_s;
  end
`else
  assign coal_s = 1'b0;
`endif

  assign alloc_s = push_s & ~coal_s;

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_s) begin
      head_d = head_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      head_d = head_q;
    end
    if (alloc_s) begin
      tail_d = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end
    case ({alloc_s, pop_s})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards everything pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; validity comes from occupancy, so contents are not reset.
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      ent_q[tail_q] <= {in_adr, in_dat};
    end
`ifdef RA_WRBUF_COALESCE_EN
    if (coal_s) begin
      ent_q[cidx_s].dat <= in_dat;
    end
`endif
  end

  // Array write port drive, zero when not writing.
  always_comb begin
    if (pop_s) begin
      wr_adr = ent_q[head_q].adr;
      wr_dat = ent_q[head_q].dat;
    end else begin
      wr_adr = {ADR_W{1'b0}};
      wr_dat = {DAT_W{1'b0}};
    end
  end

  ra_wrbuf_fwd #(
    .DEPTH  (DEPTH),
    .ADR_W  (ADR_W),
    .DAT_W  (DAT_W),
    .RD_LAT (RD_LAT)
  ) u_fwd0 (
    .clk      (clk),
    .rst_n    (reset),
    .rd_enb_i (rd0_enb),
    .rd_adr_i (rd0_adr),
    .vld_i    (vld_age_s),
    .adr_i    (adr_age_s),
    .dat_i    (dat_age_s),
    .hit_o    (fwd0_hit),
    .dat_o    (fwd0_dat)
  );

  ra_wrbuf_fwd #(
    .DEPTH  (DEPTH),
    .ADR_W  (ADR_W),
    .DAT_W  (DAT_W),
    .RD_LAT (RD_LAT)
  ) u_fwd1 (
    .clk      (clk),
    .rst_n    (reset),
    .rd_enb_i (rd1_enb),
    .rd_adr_i (rd1_adr),
    .vld_i    (vld_age_s),
    .adr_i    (adr_age_s),
    .dat_i    (dat_age_s),
    .hit_o    (fwd1_hit),
    .dat_o    (fwd1_dat)
  );

endmodule

// File: tb/tb_ra_wrbuf_sdr.sv
// Directed self-checking bench for ra_wrbuf_sdr (DEPTH=4, RD_LAT=1).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ra_wrbuf_sdr;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [5:0]  in_adr;
  logic [71:0] in_dat;
  logic        hold;
  logic        wr_enb;
  logic [5:0]  wr_adr;
  logic [71:0] wr_dat;
  logic        rd0_enb;
  logic [5:0]  rd0_adr;
  logic        rd1_enb;
  logic [5:0]  rd1_adr;
  logic        fwd0_hit;
  logic [71:0] fwd0_dat;
  logic        fwd1_hit;
  logic [71:0] fwd1_dat;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ra_wrbuf_sdr #(.DEPTH(4), .ADR_W(6), .DAT_W(72), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_adr(in_adr), .in_dat(in_dat),
    .hold(hold),
    .wr_enb(wr_enb), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .rd0_enb(rd0_enb), .rd0_adr(rd0_adr), .rd1_enb(rd1_enb), .rd1_adr(rd1_adr),
    .fwd0_hit(fwd0_hit), .fwd0_dat(fwd0_dat), .fwd1_hit(fwd1_hit), .fwd1_dat(fwd1_dat),
    .count(count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k * 0x11.. gives 0x11.., 0x22.., ... 0xff.. for k = 1..15
  function automatic logic [71:0] pat(input int k);
    logic [71:0] base;
    base = {9{8'h11}};
    return base * 72'(k);
  endfunction

  initial begin
    reset = 1'b0; in_val = 1'b0; in_adr = 6'd0; in_dat = 72'd0; hold = 1'b0;
    rd0_enb = 1'b0; rd0_adr = 6'd0; rd1_enb = 1'b0; rd1_adr = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_wr_enb", wr_enb, 0);
    check("rst_wr_adr", wr_adr, 0);
    check("rst_wr_dat", wr_dat, 0);
    check("rst_fwd0", {fwd0_hit, fwd0_dat}, 0);
    check("rst_fwd1", {fwd1_hit, fwd1_dat}, 0);
    reset = 1'b1;
    tick();

    // Streaming: 4 pushes drain back to back one cycle behind
    for (int i = 0; i < 5; i++) begin
      in_val = (i < 4);
      in_adr = 6'(2 * i);
      in_dat = pat(i + 1);
      @(negedge clk);
      check("t1_wr_enb", wr_enb, (i > 0));
      if (i > 0) begin
        check("t1_wr_adr", wr_adr, 2 * (i - 1));
        check("t1_wr_dat", wr_dat, pat(i));
      end
      tick();
    end
    @(negedge clk);
    check("t1_count_end", count, 0);
    check("t1_wr_enb_end", wr_enb, 0);
    tick();

    // Fill under hold, fifth push refused
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_val = 1'b1;
      in_adr = 6'(10 + i);
      in_dat = pat(5 + i);
      @(negedge clk);
      check("t2_count", count, i);
      check("t2_in_rdy", in_rdy, (i < 4));
      check("t2_wr_enb", wr_enb, 0);
      tick();
    end
    hold = 1'b0;
    in_val = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("t2_drain_enb", wr_enb, (j < 4));
      check("t2_drain_rdy", in_rdy, (j > 0));
      check("t2_drain_cnt", count, 4 - j);
      if (j < 4) begin
        check("t2_drain_adr", wr_adr, 10 + j);
        check("t2_drain_dat", wr_dat, pat(5 + j));
      end
      tick();
    end

    // Duplicate address under hold: youngest wins, incoming push not forwarded
    hold = 1'b1;
    in_val = 1'b1; in_adr = 6'd8; in_dat = pat(10);
    rd0_enb = 1'b1; rd0_adr = 6'd8;
    tick();
    in_dat = pat(11);
    rd0_enb = 1'b0;
    rd1_enb = 1'b1; rd1_adr = 6'd8;
    @(negedge clk);
    check("t3_push_excl", {fwd0_hit, fwd0_dat}, 0);
    tick();
    in_val = 1'b0;
    rd0_enb = 1'b1; rd0_adr = 6'd8;
    rd1_enb = 1'b1; rd1_adr = 6'd9;
    @(negedge clk);
    check("t3_fwd1_hit_a", fwd1_hit, 1);
    check("t3_fwd1_dat_a", fwd1_dat, pat(10));
    tick();
    rd0_enb = 1'b0; rd1_enb = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    check("t3_fwd0_hit", fwd0_hit, 1);
    check("t3_fwd0_dat", fwd0_dat, pat(11));
    check("t3_fwd1_miss", {fwd1_hit, fwd1_dat}, 0);
    check("t3_drain0_adr", wr_adr, 8);
`ifdef RA_WRBUF_COALESCE_EN
    check("t3_count", count, 1);
    check("t3_drain0_dat", wr_dat, pat(11));
`else
    check("t3_count", count, 2);
    check("t3_drain0_dat", wr_dat, pat(10));
`endif
    tick();
    @(negedge clk);
    check("t3_fwd_off", {fwd0_hit, fwd1_hit}, 0);
`ifdef RA_WRBUF_COALESCE_EN
    check("t3_drain1_enb", wr_enb, 0);
`else
    check("t3_drain1_enb", wr_enb, 1);
    check("t3_drain1_dat", wr_dat, pat(11));
`endif
    tick();
    @(negedge clk);
    check("t3_count_end", count, 0);
    tick();

    // Read the head entry in the cycle it drains
    hold = 1'b1;
    in_val = 1'b1; in_adr = 6'd20; in_dat = pat(12);
    tick();
    in_adr = 6'd21; in_dat = pat(13);
    tick();
    in_val = 1'b0; hold = 1'b0;
    rd0_enb = 1'b1; rd0_adr = 6'd20;
    rd1_enb = 1'b1; rd1_adr = 6'd21;
    @(negedge clk);
    check("t4_head_enb", wr_enb, 1);
    check("t4_head_adr", wr_adr, 20);
    tick();
    rd0_enb = 1'b0; rd1_enb = 1'b0;
    @(negedge clk);
    check("t4_fwd0", {fwd0_hit, fwd0_dat}, {1'b1, pat(12)});
    check("t4_fwd1", {fwd1_hit, fwd1_dat}, {1'b1, pat(13)});
    check("t4_next_adr", wr_adr, 21);
    tick();
    @(negedge clk);
    check("t4_count_end", count, 0);
    tick();

    // Reset mid-drain
    hold = 1'b1;
    in_val = 1'b1; in_adr = 6'd30; in_dat = pat(14);
    tick();
    in_adr = 6'd31; in_dat = pat(15);
    tick();
    in_adr = 6'd32; in_dat = pat(1);
    rd0_enb = 1'b1; rd0_adr = 6'd30;
    tick();
    in_val = 1'b0; rd0_enb = 1'b0; hold = 1'b0;
    @(negedge clk);
    check("t5_pre_count", count, 3);
    check("t5_pre_enb", wr_enb, 1);
    check("t5_pre_fwd0", {fwd0_hit, fwd0_dat}, {1'b1, pat(14)});
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_enb", wr_enb, 0);
    check("t5_rst_count", count, 0);
    check("t5_rst_wr", {wr_adr, wr_dat}, 0);
    check("t5_rst_fwd0", {fwd0_hit, fwd0_dat}, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("t5_post_enb", wr_enb, 0);
      check("t5_post_count", count, 0);
    end
    tick();

`ifdef RA_WRBUF_COALESCE_EN
    // Coalescing: second push to same address overwrites in place
    hold = 1'b1;
    in_val = 1'b1; in_adr = 6'd3; in_dat = pat(14);
    tick();
    in_dat = pat(15);
    tick();
    in_val = 1'b0;
    @(negedge clk);
    check("t6_count", count, 1);
    tick();
    hold = 1'b0;
    @(negedge clk);
    check("t6_drain", {wr_enb, wr_adr, wr_dat}, {1'b1, 6'd3, pat(15)});
    tick();
    @(negedge clk);
    check("t6_done", {wr_enb, count}, 0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
